stream_link_host: RTL and testbench

STREAM_LINK_HOST -- requirements
Module: stream_link_host

---
 rtl/stream_link_host_pkg.sv | 19 +
 rtl/stream_link_host_if.sv | 34 +++
 rtl/link_rx_capture.sv | 45 ++++
 rtl/stream_link_host.sv | 94 +++++++++
 tb/tb_stream_link_host.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/stream_link_host_pkg.sv
// rtl/stream_link_host_pkg.sv - shared widths and TX state encoding for the link blocks
package stream_link_host_pkg;

    localparam int LINK_DATA_WIDTH = 24;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_GAP   = 2'd2
    } tx_state_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int link_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int LINK_CNT_WIDTH = link_cnt_width(LINK_DATA_WIDTH);

endpackage

// File: rtl/stream_link_host_if.sv
// rtl/stream_link_host_if.sv - parallel/serial link signal bundle for stream_link_host
interface stream_link_host_if
    import stream_link_host_pkg::*;
#(
    parameter int DATA_WIDTH = LINK_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] iv_tx_data;
    logic                  i_tx_valid;
    logic                  o_tx_ready;
    logic                  o_link_en;
    logic                  o_link_dout;
    logic                  o_link_end;
    logic                  i_link_din;
    logic                  i_link_end;
    logic [DATA_WIDTH-1:0] ov_rx_data;
    logic                  o_rx_valid;
    logic                  i_rx_ready;
    logic                  o_rx_overrun;

    // Block side.
    modport slave (
        input  iv_tx_data, i_tx_valid, i_link_din, i_link_end, i_rx_ready,
        output o_tx_ready, o_link_en, o_link_dout, o_link_end,
               ov_rx_data, o_rx_valid, o_rx_overrun
    );

    // Host/driver side.
    modport master (
        output iv_tx_data, i_tx_valid, i_link_din, i_link_end, i_rx_ready,
        input  o_tx_ready, o_link_en, o_link_dout, o_link_end,
               ov_rx_data, o_rx_valid, o_rx_overrun
    );

endinterface

// File: rtl/link_rx_capture.sv
// rtl/link_rx_capture.sv - serial-to-parallel capture of returned frames with overrun flag
module link_rx_capture
    import stream_link_host_pkg::*;
#(
    parameter int DATA_WIDTH = LINK_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_link_din,
    input  logic                  i_link_end,
    input  logic                  i_rx_ready,
    output logic [DATA_WIDTH-1:0] ov_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_rx_overrun
);

    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] shreg_d;

    // Shift register value including this cycle's bit, so the end bit lands in the capture.
    assign shreg_d = (shreg_q << 1) | DATA_WIDTH'(i_link_din);

    // Free-running shift, capture on end marker, valid/overrun handshake bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg_q      <= '0;
            ov_rx_data   <= '0;
            o_rx_valid   <= 1'b0;
            o_rx_overrun <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            if (i_link_end) begin
                ov_rx_data <= shreg_d;
                o_rx_valid <= 1'b1;
                // A load on the same cycle the consumer takes the old sample is not an overrun.
                if (o_rx_valid && !i_rx_ready) begin
                    o_rx_overrun <= 1'b1;
                end
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_link_host.sv
// rtl/stream_link_host.sv - parallel sample to serial frame transmitter with independent serial receiver
module stream_link_host
    import stream_link_host_pkg::*;
#(
    parameter int DATA_WIDTH = LINK_DATA_WIDTH,
    parameter int GAP_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    stream_link_host_if.slave bus
);

    localparam int CW = link_cnt_width(DATA_WIDTH);
    localparam int GW = link_cnt_width(GAP_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  in_shift;

    // TX state and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= TX_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    // TX next-state: accept in IDLE, shift MSB first, then hold off for the inter-frame gap.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        unique case (state_q)
            TX_IDLE: begin
                if (bus.i_tx_valid) begin
                    shreg_d = bus.iv_tx_data;
                    cnt_d   = '0;
                    state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                shreg_d = shreg_q << 1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? TX_IDLE : TX_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = TX_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Outputs are gated by reset so they read 0 for the whole time reset is held.
    assign in_shift        = (state_q == TX_SHIFT) && !i_rst;
    assign bus.o_tx_ready  = (state_q == TX_IDLE) && !i_rst;
    assign bus.o_link_en   = in_shift;
    assign bus.o_link_dout = in_shift && shreg_q[DATA_WIDTH-1];
    assign bus.o_link_end  = in_shift && (cnt_q == CNT_LAST);

    link_rx_capture #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rx (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_link_din   (bus.i_link_din),
        .i_link_end   (bus.i_link_end),
        .i_rx_ready   (bus.i_rx_ready),
        .ov_rx_data   (bus.ov_rx_data),
        .o_rx_valid   (bus.o_rx_valid),
        .o_rx_overrun (bus.o_rx_overrun)
    );

endmodule

// File: tb/tb_stream_link_host.sv
// tb/tb_stream_link_host.sv - directed and randomized checks of stream_link_host
module tb_stream_link_host;

    localparam int DW  = 24;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   end_cnt = 0;
    logic loop_en = 1'b0;
    logic drv_din = 1'b0;
    logic drv_end = 1'b0;

    always #5 clk = ~clk;

    stream_link_host_if #(.DATA_WIDTH(DW)) bus ();
    stream_link_host_if #(.DATA_WIDTH(DW)) bus0 ();

    assign bus.i_link_din  = loop_en ? bus.o_link_dout : drv_din;
    assign bus.i_link_end  = loop_en ? bus.o_link_end  : drv_end;
    assign bus0.i_link_din = 1'b0;
    assign bus0.i_link_end = 1'b0;
    assign bus0.i_rx_ready = 1'b0;

    stream_link_host #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    stream_link_host #(.DATA_WIDTH(DW), .GAP_CYCLES(0)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0)
    );

    always @(negedge clk) begin
        if (bus.o_link_end) end_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_frame_check(input logic [DW-1:0] w);
        chk("tx_ready_before", bus.o_tx_ready, 1);
        bus.iv_tx_data = w;
        bus.i_tx_valid = 1'b1;
        step();
        bus.i_tx_valid = 1'b0;
        for (int i = 0; i < DW; i++) begin
            chk("tx_bit", {bus.o_tx_ready, bus.o_link_en, bus.o_link_end, bus.o_link_dout},
                {1'b0, 1'b1, (i == DW - 1), w[DW-1-i]});
            step();
        end
        for (int g = 0; g < GAP; g++) begin
            chk("tx_gap", {bus.o_tx_ready, bus.o_link_en, bus.o_link_end, bus.o_link_dout}, 4'b0000);
            step();
        end
        chk("tx_idle_again", {bus.o_tx_ready, bus.o_link_en}, 2'b10);
    endtask

    task automatic rx_send(input logic [DW-1:0] w, input logic rdy_at_end);
        for (int i = 0; i < DW; i++) begin
            drv_din = w[DW-1-i];
            drv_end = (i == DW - 1);
            bus.i_rx_ready = (i == DW - 1) ? rdy_at_end : 1'b0;
            step();
        end
        drv_din = 1'b0;
        drv_end = 1'b0;
        bus.i_rx_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w, a, b;
        logic [DW-1:0] bb [2];
        logic [DW-1:0] exp_q [$];
        int e0, cnt, pos, idx;

        bus.iv_tx_data  = '0;
        bus.i_tx_valid  = 1'b0;
        bus.i_rx_ready  = 1'b0;
        bus0.iv_tx_data = '0;
        bus0.i_tx_valid = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_tx_ready", bus.o_tx_ready, 0);
        chk("rst_link", {bus.o_link_en, bus.o_link_end, bus.o_link_dout}, 3'b000);
        chk("rst_rx", {bus.o_rx_valid, bus.o_rx_overrun}, 2'b00);
        chk("rst_rx_data", bus.ov_rx_data, 0);
        chk("rst_tx_ready0", bus0.o_tx_ready, 0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", bus.o_tx_ready, 1);
        chk("ready_after_rst0", bus0.o_tx_ready, 1);

        // Fixed frame, then a random frame
        tx_frame_check(24'hA5C3F0);
        step();
        tx_frame_check(DW'($urandom()));

        // Back-to-back frames with no gap while valid is held
        bb[0] = DW'($urandom());
        bb[1] = DW'($urandom());
        chk("b2b_ready", bus0.o_tx_ready, 1);
        bus0.iv_tx_data = bb[0];
        bus0.i_tx_valid = 1'b1;
        step();
        bus0.iv_tx_data = bb[1];
        for (int k = 0; k <= 2 * DW; k++) begin
            pos = k % (DW + 1);
            idx = k / (DW + 1);
            if (pos == DW)
                chk("b2b_idle", {bus0.o_tx_ready, bus0.o_link_en, bus0.o_link_end, bus0.o_link_dout}, 4'b1000);
            else
                chk("b2b_bit", {bus0.o_tx_ready, bus0.o_link_en, bus0.o_link_end, bus0.o_link_dout},
                    {1'b0, 1'b1, (pos == DW - 1), bb[idx][DW-1-pos]});
            step();
            if (k == DW) bus0.i_tx_valid = 1'b0;
        end
        chk("b2b_done", {bus0.o_tx_ready, bus0.o_link_en}, 2'b10);

        // Serial receive of a known word
        rx_send(24'h123456, 1'b0);
        chk("rx_valid", bus.o_rx_valid, 1);
        chk("rx_data", bus.ov_rx_data, 24'h123456);
        chk("rx_no_ovr", bus.o_rx_overrun, 0);

        // Second unconsumed frame overwrites and flags overrun
        a = DW'($urandom());
        rx_send(a, 1'b0);
        chk("ovr_data", bus.ov_rx_data, a);
        chk("ovr_flag", {bus.o_rx_valid, bus.o_rx_overrun}, 2'b11);
        bus.i_rx_ready = 1'b1;
        step();
        bus.i_rx_ready = 1'b0;
        chk("consume_clears", bus.o_rx_valid, 0);
        chk("ovr_sticky", bus.o_rx_overrun, 1);
        step();
        chk("ovr_sticky2", {bus.o_rx_overrun, bus.ov_rx_data}, {1'b1, a});
        rst = 1'b1;
        step();
        chk("ovr_rst", {bus.o_rx_valid, bus.o_rx_overrun}, 2'b00);
        rst = 1'b0;
        step();

        // Consume on the same cycle a new sample lands: no overrun
        a = DW'($urandom());
        b = DW'($urandom());
        rx_send(a, 1'b0);
        rx_send(b, 1'b1);
        chk("sim_consume", {bus.o_rx_valid, bus.o_rx_overrun}, 2'b10);
        chk("sim_data", bus.ov_rx_data, b);
        bus.i_rx_ready = 1'b1;
        step();
        bus.i_rx_ready = 1'b0;
        chk("sim_cleared", bus.o_rx_valid, 0);

        // Reset during bit 10 aborts the frame
        w = DW'($urandom());
        bus.iv_tx_data = w;
        bus.i_tx_valid = 1'b1;
        chk("abort_ready", bus.o_tx_ready, 1);
        step();
        bus.i_tx_valid = 1'b0;
        e0 = end_cnt;
        for (int i = 0; i < 10; i++) step();
        chk("abort_bit10", {bus.o_link_en, bus.o_link_end, bus.o_link_dout}, {1'b1, 1'b0, w[DW-11]});
        rst = 1'b1;
        step();
        chk("abort_link0", {bus.o_tx_ready, bus.o_link_en, bus.o_link_end, bus.o_link_dout}, 4'b0000);
        step();
        rst = 1'b0;
        step();
        chk("abort_ready_after", {bus.o_tx_ready, bus.o_link_en}, 2'b10);
        for (int i = 0; i < 30; i++) step();
        chk("abort_no_end", end_cnt, e0);

        // Loopback of random samples
        loop_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            w = DW'($urandom());
            exp_q.push_back(w);
            cnt = 0;
            while (!bus.o_tx_ready && cnt < 100) begin
                step();
                cnt++;
            end
            chk("lb_ready_wait", bus.o_tx_ready, 1);
            bus.iv_tx_data = w;
            bus.i_tx_valid = 1'b1;
            step();
            bus.i_tx_valid = 1'b0;
            cnt = 0;
            while (!bus.o_rx_valid && cnt < 100) begin
                step();
                cnt++;
            end
            chk("lb_rx_valid", bus.o_rx_valid, 1);
            chk("lb_rx_data", bus.ov_rx_data, exp_q.pop_front());
            bus.i_rx_ready = 1'b1;
            step();
            bus.i_rx_ready = 1'b0;
        end
        chk("lb_no_ovr", bus.o_rx_overrun, 0);
        loop_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
